pc_gen_unit: RTL and testbench

// Parametrised PC generator feeding the IFU through a valid/ready handshake. Holds the

---
 rtl/pc_gen_unit.sv | 125 ++++++++++++
 tb/tb_pc_gen_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen_unit.sv
// Fetch PC generator: holds the fetch PC behind a valid/ready handshake, applies
// prioritised redirects (ecall > mret > branch/jal > jalr) and traps misaligned targets.
module pc_gen_unit #(
    parameter int                XLEN        = 32,
    parameter logic [XLEN-1:0]   RESET_VEC   = XLEN'(32'h8000_0000),
    parameter int                STEP        = 4,
    parameter int                IALIGN      = 4,
    parameter int                BOOT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_stall,
    input  logic            i_ready,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    input  logic [XLEN-1:0] i_src_pc,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_data_Rs1,
    input  logic            i_branch_en,
    input  logic            i_zero,
    input  logic            i_jal_jump_en,
    input  logic            i_jalr_jump_en,
    input  logic            i_ecall_en,
    input  logic            i_mret_en,
    input  logic [XLEN-1:0] i_mtvec,
    input  logic [XLEN-1:0] i_mepc,
    output logic            o_redirect,
    output logic            o_misalign,
    output logic [XLEN-1:0] o_bad_addr
);

    localparam logic [0:0]      ST_BOOT    = 1'b0;
    localparam logic [0:0]      ST_RUN     = 1'b1;
    localparam logic [0:0]      ST_RESET   = (BOOT_CYCLES == 0) ? ST_RUN : ST_BOOT;
    localparam logic [3:0]      BOOT_LAST  = 4'(BOOT_CYCLES - 1);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);
    localparam logic [XLEN-1:0] STEP_V     = XLEN'(STEP);

    logic [0:0]      state_q, state_d;
    logic [3:0]      boot_cnt_q, boot_cnt_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            redirect_q, redirect_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] bad_addr_q, bad_addr_d;

    logic            run, fire, take, checked;
    logic [XLEN-1:0] target;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        pc_d       = pc_q;
        redirect_d = 1'b0;
        misalign_d = 1'b0;
        bad_addr_d = bad_addr_q;
        take       = 1'b0;
        checked    = 1'b0;
        target     = '0;

        run     = (state_q == ST_RUN);
        o_valid = run & ~i_stall;
        fire    = o_valid & i_ready;

        if (!run) begin
            boot_cnt_d = boot_cnt_q + 4'd1;
            if (boot_cnt_q == BOOT_LAST) state_d = ST_RUN;
        end else begin
            if (i_ecall_en) begin
                take   = 1'b1;
                target = i_mtvec;
            end else if (i_mret_en) begin
                take   = 1'b1;
                target = i_mepc & ~ALIGN_MASK;
            end else if ((i_branch_en & ~i_zero) | i_jal_jump_en) begin
                take    = 1'b1;
                checked = 1'b1;
                target  = i_src_pc + i_imm;
            end else if (i_jalr_jump_en) begin
                take    = 1'b1;
                checked = 1'b1;
                target  = (i_data_Rs1 + i_imm) & ~XLEN'(1);
            end

            // A redirect overrides the sequential step even when fetch accepts this cycle.
            if (take) begin
                redirect_d = 1'b1;
                if (checked && ((target & ALIGN_MASK) != '0)) begin
                    pc_d       = i_mtvec;
                    misalign_d = 1'b1;
                    bad_addr_d = target;
                end else begin
                    pc_d = target;
                end
            end else if (fire) begin
                pc_d = pc_q + STEP_V;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_RESET;
            boot_cnt_q <= '0;
            pc_q       <= RESET_VEC;
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
            bad_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            misalign_q <= misalign_d;
            bad_addr_q <= bad_addr_d;
        end
    end

    assign o_pc       = pc_q;
    assign o_redirect = redirect_q;
    assign o_misalign = misalign_q;
    assign o_bad_addr = bad_addr_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Bench for pc_gen_unit: reset/boot and async-reset sequences by hand, steady-state
// behaviour from a vector table whose expectations go through a scoreboard queue.
module tb_pc_gen_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_stall, i_ready;
    logic        o_valid;
    logic [31:0] o_pc;
    logic [31:0] i_src_pc, i_imm, i_data_Rs1;
    logic        i_branch_en, i_zero, i_jal_jump_en, i_jalr_jump_en, i_ecall_en, i_mret_en;
    logic [31:0] i_mtvec, i_mepc;
    logic        o_redirect, o_misalign;
    logic [31:0] o_bad_addr;

    pc_gen_unit dut (
        .clk            (clk),
        .rstn           (rstn),
        .i_stall        (i_stall),
        .i_ready        (i_ready),
        .o_valid        (o_valid),
        .o_pc           (o_pc),
        .i_src_pc       (i_src_pc),
        .i_imm          (i_imm),
        .i_data_Rs1     (i_data_Rs1),
        .i_branch_en    (i_branch_en),
        .i_zero         (i_zero),
        .i_jal_jump_en  (i_jal_jump_en),
        .i_jalr_jump_en (i_jalr_jump_en),
        .i_ecall_en     (i_ecall_en),
        .i_mret_en      (i_mret_en),
        .i_mtvec        (i_mtvec),
        .i_mepc         (i_mepc),
        .o_redirect     (o_redirect),
        .o_misalign     (o_misalign),
        .o_bad_addr     (o_bad_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, ready, branch, zero, jal, jalr, ecall, mret;
        logic [31:0] src_pc, imm, rs1, mtvec, mepc;
        logic [31:0] exp_pc, exp_bad;
        logic        exp_red, exp_mis;
    } vec_t;

    typedef struct {
        logic [31:0] pc, bad;
        logic        valid, red, mis;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] bad_hold = 32'h0;
    vec_t        tbl[$];
    exp_t        sb[$];
    vec_t        v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t dflt();
        vec_t d;
        d = '{stall: 1'b0, ready: 1'b1, branch: 1'b0, zero: 1'b0, jal: 1'b0, jalr: 1'b0,
              ecall: 1'b0, mret: 1'b0, src_pc: 32'h0, imm: 32'h0, rs1: 32'h0,
              mtvec: 32'h8000_1000, mepc: 32'h0, exp_pc: 32'h0, exp_bad: bad_hold,
              exp_red: 1'b0, exp_mis: 1'b0};
        return d;
    endfunction

    task automatic drive(input vec_t x);
        i_stall = x.stall;  i_ready = x.ready;  i_branch_en = x.branch; i_zero = x.zero;
        i_jal_jump_en = x.jal; i_jalr_jump_en = x.jalr; i_ecall_en = x.ecall;
        i_mret_en = x.mret; i_src_pc = x.src_pc; i_imm = x.imm; i_data_Rs1 = x.rs1;
        i_mtvec = x.mtvec;  i_mepc = x.mepc;
    endtask

    // Drive at the falling edge, record the expectation, compare 1 time unit after the rising edge.
    task automatic apply(input int idx, input vec_t x);
        exp_t e;
        drive(x);
        sb.push_back('{pc: x.exp_pc, bad: x.exp_bad, valid: !x.stall, red: x.exp_red, mis: x.exp_mis});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check($sformatf("v%0d_scoreboard_empty", idx), 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check($sformatf("v%0d_pc", idx),       o_pc,       e.pc);
            check($sformatf("v%0d_valid", idx),    o_valid,    e.valid);
            check($sformatf("v%0d_redirect", idx), o_redirect, e.red);
            check($sformatf("v%0d_misalign", idx), o_misalign, e.mis);
            check($sformatf("v%0d_bad_addr", idx), o_bad_addr, e.bad);
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rstn = 1'b0;
        drive(dflt());

        // Sequential fetch, backpressure and stall.
        v = dflt(); v.exp_pc = 32'h8000_0004; tbl.push_back(v);
        v = dflt(); v.exp_pc = 32'h8000_0008; tbl.push_back(v);
        v = dflt(); v.exp_pc = 32'h8000_000C; tbl.push_back(v);
        v = dflt(); v.exp_pc = 32'h8000_0010; tbl.push_back(v);
        for (int k = 0; k < 3; k++) begin
            v = dflt(); v.ready = 1'b0; v.exp_pc = 32'h8000_0010; tbl.push_back(v);
        end
        v = dflt(); v.stall = 1'b1; v.exp_pc = 32'h8000_0010; tbl.push_back(v);
        // Taken backward branch wins over fire; untaken branch just steps.
        v = dflt(); v.branch = 1'b1; v.src_pc = 32'h8000_0020; v.imm = 32'hFFFF_FFF0;
        v.exp_pc = 32'h8000_0010; v.exp_red = 1'b1; tbl.push_back(v);
        v = dflt(); v.branch = 1'b1; v.zero = 1'b1; v.src_pc = 32'h8000_0020; v.imm = 32'hFFFF_FFF0;
        v.exp_pc = 32'h8000_0014; tbl.push_back(v);
        // ecall beats a misaligned jal: no trap.
        v = dflt(); v.ecall = 1'b1; v.jal = 1'b1; v.src_pc = 32'h8000_0000; v.imm = 32'h2;
        v.exp_pc = 32'h8000_1000; v.exp_red = 1'b1; tbl.push_back(v);
        v = dflt(); v.exp_pc = 32'h8000_1004; tbl.push_back(v);
        // Misaligned jalr traps to mtvec.
        bad_hold = 32'h8000_0002;
        v = dflt(); v.jalr = 1'b1; v.rs1 = 32'h8000_0002;
        v.exp_pc = 32'h8000_1000; v.exp_red = 1'b1; v.exp_mis = 1'b1; tbl.push_back(v);
        v = dflt(); v.ready = 1'b0; v.exp_pc = 32'h8000_1000; tbl.push_back(v);
        // mret clears low bits; jalr clears bit 0; redirect still applies under stall.
        v = dflt(); v.mret = 1'b1; v.mepc = 32'h8000_0107;
        v.exp_pc = 32'h8000_0104; v.exp_red = 1'b1; tbl.push_back(v);
        v = dflt(); v.jalr = 1'b1; v.rs1 = 32'h8000_0203; v.imm = 32'h1;
        v.exp_pc = 32'h8000_0204; v.exp_red = 1'b1; tbl.push_back(v);
        v = dflt(); v.stall = 1'b1; v.jal = 1'b1; v.src_pc = 32'h8000_0200; v.imm = 32'h8;
        v.exp_pc = 32'h8000_0208; v.exp_red = 1'b1; tbl.push_back(v);
        bad_hold = 32'h8000_0006;
        v = dflt(); v.branch = 1'b1; v.src_pc = 32'h8000_0000; v.imm = 32'h6;
        v.exp_pc = 32'h8000_1000; v.exp_red = 1'b1; v.exp_mis = 1'b1; tbl.push_back(v);
        // jal over jalr, mret over branch.
        v = dflt(); v.jal = 1'b1; v.jalr = 1'b1; v.src_pc = 32'h8000_0000; v.imm = 32'h40;
        v.rs1 = 32'h0; v.exp_pc = 32'h8000_0040; v.exp_red = 1'b1; tbl.push_back(v);
        v = dflt(); v.mret = 1'b1; v.mepc = 32'h8000_0300; v.branch = 1'b1; v.src_pc = 32'h8000_0000;
        v.imm = 32'h100; v.exp_pc = 32'h8000_0300; v.exp_red = 1'b1; tbl.push_back(v);
        // PC wrap at the top of the address space.
        v = dflt(); v.ecall = 1'b1; v.mtvec = 32'hFFFF_FFFC;
        v.exp_pc = 32'hFFFF_FFFC; v.exp_red = 1'b1; tbl.push_back(v);
        v = dflt(); v.exp_pc = 32'h0000_0000; tbl.push_back(v);
        // A held jal re-redirects every cycle.
        for (int k = 0; k < 2; k++) begin
            v = dflt(); v.jal = 1'b1; v.src_pc = 32'h8000_0000; v.imm = 32'h10;
            v.exp_pc = 32'h8000_0010; v.exp_red = 1'b1; tbl.push_back(v);
        end

        // Reset values and boot delay.
        #12;
        check("rst_pc", o_pc, 32'h8000_0000);
        check("rst_valid", o_valid, 32'd0);
        check("rst_redirect", o_redirect, 32'd0);
        check("rst_misalign", o_misalign, 32'd0);
        check("rst_bad_addr", o_bad_addr, 32'h0);
        v = dflt(); v.ecall = 1'b1; v.mtvec = 32'h1234_5670;
        drive(v);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("boot0_valid", o_valid, 32'd0);
        @(posedge clk); #1;
        check("boot1_valid", o_valid, 32'd0);
        check("boot1_pc_ignores_ecall", o_pc, 32'h8000_0000);
        drive(dflt());
        @(posedge clk); #1;
        check("run_valid", o_valid, 32'd1);
        check("run_pc", o_pc, 32'h8000_0000);
        check("run_redirect", o_redirect, 32'd0);
        @(negedge clk);

        foreach (tbl[i]) apply(i, tbl[i]);

        // Asynchronous reset while a redirect pulse is in flight.
        v = dflt(); v.jal = 1'b1; v.src_pc = 32'h8000_0000; v.imm = 32'h20;
        drive(v);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_pc", o_pc, 32'h8000_0000);
        check("async_rst_valid", o_valid, 32'd0);
        check("async_rst_redirect", o_redirect, 32'd0);
        check("async_rst_bad_addr", o_bad_addr, 32'h0);
        @(posedge clk); #1;
        check("async_rst_hold_pc", o_pc, 32'h8000_0000);
        check("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
